pcint_e_receiver: RTL
=====================

// Module: pcint_e_receiver
// PURPOSE
//  Input-side companion to the Port E pin driver. It synchronises PE[3:0] pad inputs, detects pin changes on
//  PCINT[27:24] and owns the PCMSK3 mask register and the PCIF3 flag. It raises the PCINT3 interrupt request to
//  the interrupt controller. Its pinE_sync and PCINT outputs feed the Port E PINx and DIE logic. It sits on the
//  6-bit IO bus next to the Port E IO_Port instance.
// PARAMETERS
//  port_width     4      number of pins handled (bits [port_width-1:0])
//  SYNC_STAGES    2      synchroniser flops ahead of the edge-detect flop (>=2)
//  PCMSK_Address  6'h33  IO address of PCMSK3 (R/W, upper 8-port_width bits read 0)
//  PCIFR_Address  6'h1b  IO address of PCIFR (shared register, this block owns one bit)
//  PCIF_Bit       3      bit position of PCIF3 inside PCIFR
// PORTS
//  cp2         in   1   clock
//  ireset      in   1   synchronous active-high reset
//  IO_Addr     in   6   IO register address
//  iore        in   1   IO read strobe
//  iowe        in   1   IO write strobe
//  dbus_in     in   8   IO write data
//  dbus_out    out  8   IO read data (0 when not selected)
//  out_en      out  1   high when this block drives dbus_out
//  pinE_i      in   4   raw asynchronous pad inputs
//  PCIE3       in   1   pin-change group enable from PCICR
//  irq_ack     in   1   1-cycle pulse: PCINT3 vector taken
//  pinE_sync   out  4   synchronised pin levels (PINE read source)
//  PCINT       out  4   PCMSK3[3:0] (to Port E DIE override logic)
//  PCIF3       out  1   pin-change flag
//  pcint3_irq  out  1   interrupt request = PCIF3 & PCIE3
// BEHAVIOUR
//  Reset: all sync/edge flops, PCMSK3, PCIF3 and the arm counter are 0. All outputs are 0.
//  Sync chain: s[0] <= pinE_i; s[i] <= s[i-1]. pinE_sync = s[SYNC_STAGES-1]. prev <= pinE_sync.
//  change[n] = (pinE_sync[n] ^ prev[n]) & PCMSK3[n]. Both edges count.
//  Arm counter: 2-bit saturating counter, +1 per cycle after reset. Change detection is ignored until it
//   reaches SYNC_STAGES+1. This prevents a false flag from pins already high at reset.
//  Flag set: PCIF3 <= 1 when armed & PCIE3 & |change.
//  Flag clear: IO write (iowe & IO_Addr==PCIFR_Address & dbus_in[PCIF_Bit]==1), or irq_ack. Writing 0 has no
//   effect. Set wins over clear in the same cycle.
//  Latency (SYNC_STAGES=2): a pad edge that settles before clock edge k gives pinE_sync at edge k+1 and
//   PCIF3/pcint3_irq high after edge k+2.
//  Glitches shorter than one cycle may be missed. A toggle that returns within one cycle is not guaranteed.
//  PCMSK3 write: iowe & IO_Addr==PCMSK_Address. PCMSK3 <= dbus_in[port_width-1:0]. Effective for change
//   detection from the next cycle.
//  Reads are combinational:
//   - out_en = iore & (addr==PCMSK_Address | addr==PCIFR_Address).
//   - PCMSK read: {0,PCMSK3}.
//   - PCIFR read: PCIF3 at PCIF_Bit, all other bits 0. The top level ORs this with other PCIFR owners.
//  PCIE3 low: no new flag set. An existing PCIF3 is held, and pcint3_irq is 0 until PCIE3 returns high.
//  ireset mid-operation: next cycle is in reset state. The arm counter restarts.
//  Multiple pins toggling in one cycle set the flag once. A toggle while PCIF3=1 changes nothing.
// TESTING
//  1. Reset with pinE_i=4'hF, PCMSK3=4'hF, PCIE3=1 -> PCIF3 stays 0 for 20 cycles.
//  2. PCMSK3=4'b0100, PCIE3=1, pinE_i[2] 0->1 before edge k -> pinE_sync[2]=1 after k+1, PCIF3=1 and
//     pcint3_irq=1 after k+2. Toggle pinE_i[1] -> no flag.
//  3. PCIF3=1, write 8'h08 to 6'h1b -> PCIF3=0 next cycle. Write 8'h00 -> PCIF3 unchanged.
//  4. irq_ack coincides with a new enabled change on pinE_i[3] -> PCIF3 remains 1.
//  5. PCIE3=0, toggle masked pin -> PCIF3=0. PCIF3 preset with PCIE3=0 -> pcint3_irq=0, becomes 1 when
//     PCIE3=1.
//  6. iore at 6'h33 with PCMSK3=4'hA -> out_en=1, dbus_out=8'h0A. Other address -> out_en=0, dbus_out=8'h00.

Source files
------------

// File: rtl/pcint_e_receiver.sv
// Port E pin-change receiver: synchronises PE[3:0], detects masked edges on PCINT[27:24],
// and owns PCMSK3 plus the PCIF3 bit of the shared PCIFR register.
module pcint_e_receiver #(
  parameter int unsigned port_width    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [5:0]  PCMSK_Address = 6'h33,
  parameter logic [5:0]  PCIFR_Address = 6'h1b,
  parameter int unsigned PCIF_Bit      = 3
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic [5:0]            IO_Addr,
  input  logic                  iore,
  input  logic                  iowe,
  input  logic [7:0]            dbus_in,
  output logic [7:0]            dbus_out,
  output logic                  out_en,
  input  logic [port_width-1:0] pinE_i,
  input  logic                  PCIE3,
  input  logic                  irq_ack,
  output logic [port_width-1:0] pinE_sync,
  output logic [port_width-1:0] PCINT,
  output logic                  PCIF3,
  output logic                  pcint3_irq
);

  localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  // IO bus: iore/iowe are single-cycle strobes qualified by IO_Addr; there is no
  // back-pressure, reads are combinational and writes take effect at the next edge.

  logic [port_width-1:0] sync_q [SYNC_STAGES];
  logic [port_width-1:0] prev_q;
  logic [port_width-1:0] pcmsk_q;
  logic [port_width-1:0] change;
  logic [ARM_W-1:0]      arm_cnt_q;
  logic                  pcif_q;
  logic                  armed;
  logic                  flag_set;
  logic                  flag_clr;
  logic                  sel_pcmsk;
  logic                  sel_pcifr;

  assign sel_pcmsk = (IO_Addr == PCMSK_Address);
  assign sel_pcifr = (IO_Addr == PCIFR_Address);

  assign pinE_sync = sync_q[SYNC_STAGES-1];
  assign change    = (pinE_sync ^ prev_q) & pcmsk_q;
  // Edges are ignored until the chain and prev hold real pad data, so pins high at reset don't flag.
  assign armed     = (arm_cnt_q == ARM_MAX);
  assign flag_set  = armed & PCIE3 & (|change);
  assign flag_clr  = (iowe & sel_pcifr & dbus_in[PCIF_Bit]) | irq_ack;

  always_ff @(posedge cp2) begin
    if (ireset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      pcmsk_q   <= '0;
      arm_cnt_q <= '0;
      pcif_q    <= 1'b0;
    end else begin
      sync_q[0] <= pinE_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= pinE_sync;
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
      if (iowe && sel_pcmsk) pcmsk_q <= dbus_in[port_width-1:0];
      // A new change outranks a simultaneous clear so no edge is lost.
      if (flag_set)      pcif_q <= 1'b1;
      else if (flag_clr) pcif_q <= 1'b0;
    end
  end

  assign PCINT      = pcmsk_q;
  assign PCIF3      = pcif_q;
  assign pcint3_irq = pcif_q & PCIE3;

  always_comb begin
    out_en   = 1'b0;
    dbus_out = 8'h00;
    if (iore && sel_pcmsk) begin
      out_en   = 1'b1;
      dbus_out = 8'(pcmsk_q);
    end else if (iore && sel_pcifr) begin
      out_en   = 1'b1;
      dbus_out = 8'(pcif_q) << PCIF_Bit;
    end
  end

endmodule
